// File: rtl/vga_sync_gen.sv
// Parametrised VGA timing generator with registered, mutually aligned outputs.
// Optional frame counter output vga_frame: define VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int H_DISPLAY     = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_DISPLAY     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int H_SYNC_POL    = 0,
    parameter int V_SYNC_POL    = 0,
    parameter int H_SIZE        = 10,
    parameter int V_SIZE        = 10
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst,
    input  logic              sync_en,
    input  logic              pixel_ce,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [H_SIZE-1:0] vga_hc,
    output logic [V_SIZE-1:0] vga_vc,
    output logic              vga_on,
    output logic              line_start,
    output logic              frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0]        vga_frame
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT_PORCH
                           + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT_PORCH
                           + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HW = H_SIZE + 1;
    localparam int VW = V_SIZE + 1;

    // One extra bit keeps the window ends representable at full counter range.
    localparam logic [HW-1:0] H_ACT_END = HW'(H_DISPLAY);
    localparam logic [HW-1:0] H_SS      = HW'(H_DISPLAY + H_FRONT_PORCH);
    localparam logic [HW-1:0] H_SE      = HW'(H_DISPLAY + H_FRONT_PORCH
                                              + H_SYNC_PULSE);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_DISPLAY);
    localparam logic [VW-1:0] V_SS      = VW'(V_DISPLAY + V_FRONT_PORCH);
    localparam logic [VW-1:0] V_SE      = VW'(V_DISPLAY + V_FRONT_PORCH
                                              + V_SYNC_PULSE);
    localparam logic [H_SIZE-1:0] H_LAST = H_SIZE'(H_TOTAL - 1);
    localparam logic [V_SIZE-1:0] V_LAST = V_SIZE'(V_TOTAL - 1);
    localparam logic HS_ACT = 1'(H_SYNC_POL);
    localparam logic VS_ACT = 1'(V_SYNC_POL);

    generate
        if (H_TOTAL > (1 << H_SIZE)) begin : g_h_chk
            $error("H_TOTAL exceeds 2**H_SIZE");
        end
        if (V_TOTAL > (1 << V_SIZE)) begin : g_v_chk
            $error("V_TOTAL exceeds 2**V_SIZE");
        end
    endgenerate

    logic [H_SIZE-1:0] h_q, h_d, hc_q, hc_d;
    logic [V_SIZE-1:0] v_q, v_d, vc_q, vc_d;
    logic              on_q, on_d, hs_q, hs_d, vs_q, vs_d;
    logic              ls_q, ls_d, fs_q, fs_d;
    logic [HW-1:0]     h_ext;
    logic [VW-1:0]     v_ext;

    assign h_ext = {1'b0, h_q};
    assign v_ext = {1'b0, v_q};

    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        hc_d = hc_q;
        vc_d = vc_q;
        on_d = on_q;
        hs_d = hs_q;
        vs_d = vs_q;
        // Strobes sample every edge so they stay one clock wide under a divided ce.
        ls_d = pixel_ce & sync_en & (h_q == '0);
        fs_d = ls_d & (v_q == '0);
        if (!sync_en) begin
            h_d  = '0;
            v_d  = '0;
            hc_d = '0;
            vc_d = '0;
            on_d = 1'b0;
            hs_d = ~HS_ACT;
            vs_d = ~VS_ACT;
        end else if (pixel_ce) begin
            hc_d = h_q;
            vc_d = v_q;
            on_d = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
            hs_d = (h_ext >= H_SS && h_ext < H_SE) ? HS_ACT : ~HS_ACT;
            vs_d = (v_ext >= V_SS && v_ext < V_SE) ? VS_ACT : ~VS_ACT;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            h_q  <= '0;
            v_q  <= '0;
            hc_q <= '0;
            vc_q <= '0;
            on_q <= 1'b0;
            hs_q <= ~HS_ACT;
            vs_q <= ~VS_ACT;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hc_q <= hc_d;
            vc_q <= vc_d;
            on_q <= on_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign vga_hc      = hc_q;
    assign vga_vc      = vc_q;
    assign vga_on      = on_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_q, frame_d;
    logic       first_q, first_d;

    // The first frame after reset or enable reports 0, later frames count up.
    always_comb begin
        frame_d = frame_q;
        first_d = first_q;
        if (!sync_en) begin
            frame_d = '0;
            first_d = 1'b1;
        end else if (fs_d) begin
            if (first_q) begin
                first_d = 1'b0;
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            frame_q <= '0;
            first_q <= 1'b1;
        end else begin
            frame_q <= frame_d;
            first_q <= first_d;
        end
    end

    assign vga_frame = frame_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: small mode (both polarities) and default mode.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_en = 1'b1;
    logic pixel_ce = 1'b1;

    always #5 clk = ~clk;

`ifdef VGA_SYNC_FRAME_CNT_EN
    localparam bit FRM_EN = 1'b1;
`else
    localparam bit FRM_EN = 1'b0;
`endif

    logic       hs0, vs0, on0, ls0, fs0;
    logic [3:0] hc0, vc0;
    logic [7:0] fr0;
    logic       hs1, vs1, on1, ls1, fs1;
    logic [3:0] hc1, vc1;
    logic [7:0] fr1;
    logic       hsd, vsd, ond, lsd, fsd;
    logic [9:0] hcd, vcd;
    logic [7:0] frd;

    vga_sync_gen #(
        .H_DISPLAY(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
        .V_DISPLAY(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .H_SIZE(4), .V_SIZE(4)
    ) dut_s0 (
        .pixel_clk(clk), .pixel_rst(rst), .sync_en(sync_en),
        .pixel_ce(pixel_ce), .vga_hsync(hs0), .vga_vsync(vs0),
        .vga_hc(hc0), .vga_vc(vc0), .vga_on(on0),
        .line_start(ls0), .frame_start(fs0)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .vga_frame(fr0)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
        .V_DISPLAY(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .H_SIZE(4), .V_SIZE(4)
    ) dut_s1 (
        .pixel_clk(clk), .pixel_rst(rst), .sync_en(sync_en),
        .pixel_ce(pixel_ce), .vga_hsync(hs1), .vga_vsync(vs1),
        .vga_hc(hc1), .vga_vc(vc1), .vga_on(on1),
        .line_start(ls1), .frame_start(fs1)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .vga_frame(fr1)
`endif
    );

    vga_sync_gen dut_d (
        .pixel_clk(clk), .pixel_rst(rst), .sync_en(sync_en),
        .pixel_ce(pixel_ce), .vga_hsync(hsd), .vga_vsync(vsd),
        .vga_hc(hcd), .vga_vc(vcd), .vga_on(ond),
        .line_start(lsd), .frame_start(fsd)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .vga_frame(frd)
`endif
    );

`ifndef VGA_SYNC_FRAME_CNT_EN
    assign fr0 = '0;
    assign fr1 = '0;
    assign frd = '0;
`endif

    typedef struct {
        int hd, hf, hs, hb, vd, vf, vs, vb;
    } mode_t;

    typedef struct {
        int h, v, hc, vc, fr;
        bit on, hs, vs, ls, fs, first;
    } mdl_t;

    typedef struct {
        mdl_t s;
        mdl_t d;
        int   per;
    } exp_t;

    mode_t ps = '{4, 1, 2, 1, 3, 1, 1, 1};
    mode_t pd = '{640, 16, 96, 48, 480, 10, 2, 33};
    mdl_t  ms, md;
    exp_t  q[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [39:0] act,
                       input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] pk(
        input logic hs, input logic vs, input logic [9:0] hc,
        input logic [9:0] vc, input logic on, input logic ls,
        input logic fs, input logic [7:0] fr);
        return {7'd0, hs, vs, hc, vc, on, ls, fs, fr};
    endfunction

    task automatic minit(output mdl_t m);
        m = '{h: 0, v: 0, hc: 0, vc: 0, fr: 0,
              on: 0, hs: 0, vs: 0, ls: 0, fs: 0, first: 1};
    endtask

    task automatic mstep(inout mdl_t m, input mode_t p,
                         input bit en, input bit ce);
        int ht, vt;
        bit ls, fs;
        ht = p.hd + p.hf + p.hs + p.hb;
        vt = p.vd + p.vf + p.vs + p.vb;
        ls = en && ce && (m.h == 0);
        fs = ls && (m.v == 0);
        if (!en) begin
            minit(m);
        end else begin
            m.ls = ls;
            m.fs = fs;
            if (fs) begin
                if (m.first) m.first = 0;
                else m.fr = (m.fr + 1) % 256;
            end
            if (ce) begin
                m.hc = m.h;
                m.vc = m.v;
                m.on = (m.h < p.hd) && (m.v < p.vd);
                m.hs = (m.h >= p.hd + p.hf) && (m.h < p.hd + p.hf + p.hs);
                m.vs = (m.v >= p.vd + p.vf) && (m.v < p.vd + p.vf + p.vs);
                if (m.h == ht - 1) begin
                    m.h = 0;
                    m.v = (m.v == vt - 1) ? 0 : m.v + 1;
                end else begin
                    m.h = m.h + 1;
                end
            end
        end
    endtask

    task automatic cyc(input bit en, input bit ce, input int per);
        exp_t e;
        @(negedge clk);
        sync_en  = en;
        pixel_ce = ce;
        mstep(ms, ps, en, ce);
        mstep(md, pd, en, ce);
        e.s = ms;
        e.d = md;
        e.per = per;
        q.push_back(e);
    endtask

    function automatic logic [39:0] epk(input mdl_t m, input bit pol);
        return pk(pol ? m.hs : !m.hs, pol ? m.vs : !m.vs,
                  10'(m.hc), 10'(m.vc), m.on, m.ls, m.fs,
                  FRM_EN ? 8'(m.fr) : 8'd0);
    endfunction

    int max_hc = 0;
    int max_vc = 0;
    int max_hcd = 0;

    // Monitor: one expected entry per clock edge driven by the stimulus.
    initial begin
        exp_t e;
        int ncyc = 0;
        int last_ls = -1;
        int last_per = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                ncyc++;
                chk("s0", pk(hs0, vs0, 10'(hc0), 10'(vc0), on0, ls0, fs0, fr0),
                    epk(e.s, 1'b0));
                chk("s1", pk(hs1, vs1, 10'(hc1), 10'(vc1), on1, ls1, fs1, fr1),
                    epk(e.s, 1'b1));
                chk("d", pk(hsd, vsd, hcd, vcd, ond, lsd, fsd, frd),
                    epk(e.d, 1'b0));
                if (int'(hc0) > max_hc) max_hc = int'(hc0);
                if (int'(vc0) > max_vc) max_vc = int'(vc0);
                if (int'(hcd) > max_hcd) max_hcd = int'(hcd);
                if (lsd === 1'b1) begin
                    if (last_ls >= 0 && e.per != 0 && e.per == last_per)
                        chk("ls_period", 40'(ncyc - last_ls), 40'(e.per));
                    last_ls = ncyc;
                    last_per = e.per;
                end
            end
        end
    end

    initial begin
        int guard;
        minit(ms);
        minit(md);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_s0", pk(hs0, vs0, 10'(hc0), 10'(vc0), on0, ls0, fs0, fr0),
            pk(1, 1, 0, 0, 0, 0, 0, 0));
        chk("rst_s1", pk(hs1, vs1, 10'(hc1), 10'(vc1), on1, ls1, fs1, fr1),
            pk(0, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_d", pk(hsd, vsd, hcd, vcd, ond, lsd, fsd, frd),
            pk(1, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        sync_en = 1'b0;

        repeat (2000) cyc(1, 1, 800);
        for (int i = 0; i < 3400; i++) cyc(1, (i % 2) == 0, 1600);

        guard = 0;
        while (!(ms.h == 3 && ms.v == 2) && guard < 100) begin
            cyc(1, 1, 0);
            guard++;
        end
        chk("reach_drop", 40'(guard < 100), 40'd1);
        cyc(0, 0, 0);
        @(posedge clk);
        #2;
        chk("idle_s0", pk(hs0, vs0, 10'(hc0), 10'(vc0), on0, ls0, fs0, fr0),
            pk(1, 1, 0, 0, 0, 0, 0, 0));
        chk("idle_s1_sync", 40'({hs1, vs1}), 40'd0);
        repeat (4) cyc(0, 1, 0);
        cyc(1, 1, 0);
        @(posedge clk);
        #2;
        chk("restart_s0", pk(hs0, vs0, 10'(hc0), 10'(vc0), on0, ls0, fs0, fr0),
            pk(1, 1, 0, 0, 1, 1, 1, 0));
        repeat (300) cyc(1, 1, 0);

        cyc(0, 1, 0);
        repeat (255 * 48 + 1) cyc(1, 1, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        @(posedge clk);
        #2;
        chk("frame_255", 40'(fr0), 40'd255);
`endif
        repeat (48) cyc(1, 1, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        @(posedge clk);
        #2;
        chk("frame_wrap", 40'(fr0), 40'd0);
`endif
        repeat (3) @(posedge clk);
        #2;
        chk("q_empty", 40'(q.size()), 40'd0);
        chk("max_hc", 40'(max_hc), 40'd7);
        chk("max_vc", 40'(max_vc), 40'd5);
        chk("max_hcd", 40'(max_hcd), 40'd799);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Parametrised VGA timing generator, the next generation of the fixed-timing sync core. All timing fields are module parameters, so any mode can be instantiated without editing the shared timing header. Adds sync polarity control, a pixel clock-enable for divided pixel rates, a run/idle enable, registered (glitch-free) aligned outputs, and line/frame start strobes. Sits between the pixel clock domain and the pixel generator / VGA pins.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT_PORCH, 16, horizontal front porch in pixels
H_SYNC_PULSE, 96, hsync width in pixels
H_BACK_PORCH, 48, horizontal back porch in pixels
V_DISPLAY, 480, active lines per frame
V_FRONT_PORCH, 10, vertical front porch in lines
V_SYNC_PULSE, 2, vsync width in lines
V_BACK_PORCH, 33, vertical back porch in lines
H_SYNC_POL, 0, active level of vga_hsync (0 = active-low)
V_SYNC_POL, 0, active level of vga_vsync
H_SIZE, 10, width of the horizontal count; H_TOTAL must be <= 2**H_SIZE (elaboration error otherwise)
V_SIZE, 10, width of the vertical count; V_TOTAL must be <= 2**V_SIZE

Ports:
pixel_clk  input  1  pixel clock
pixel_rst  input  1  reset, asynchronous, active-high
sync_en  input  1  1 = run; 0 = hold in idle
pixel_ce  input  1  pixel tick qualifier; tie to 1 for full rate
vga_hsync  output  1  horizontal sync, polarity H_SYNC_POL
vga_vsync  output  1  vertical sync, polarity V_SYNC_POL
vga_hc  output  H_SIZE  horizontal count of current output pixel
vga_vc  output  V_SIZE  vertical count of current output pixel
vga_on  output  1  active video region
line_start  output  1  one-cycle strobe, first pixel of each line
frame_start  output  1  one-cycle strobe, first pixel of each frame

Behaviour:
- Single clock, pixel_clk. pixel_rst is asynchronous, active-high.
- H_TOTAL = sum of the H fields; V_TOTAL = sum of the V fields.
- Internal counters h_cnt and v_cnt advance only when sync_en=1 and pixel_ce=1.
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt increments when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- Output stage: one register stage. On each qualifying tick it captures the decode of the current (h_cnt, v_cnt):
  - vga_hc = h_cnt and vga_vc = v_cnt.
  - vga_on = (h_cnt < H_DISPLAY) & (v_cnt < V_DISPLAY).
  - hsync is active when H_DISPLAY+H_FRONT_PORCH <= h_cnt < H_DISPLAY+H_FRONT_PORCH+H_SYNC_PULSE.
  - vsync is active when V_DISPLAY+V_FRONT_PORCH <= v_cnt < V_DISPLAY+V_FRONT_PORCH+V_SYNC_PULSE.
  - All outputs are therefore mutually aligned. Latency from counter to output is one tick.
- When pixel_ce=0, the output registers hold.
- Strobes:
  - line_start <= pixel_ce & sync_en & (h_cnt==0), updated every pixel_clk edge. It is high for exactly one pixel_clk cycle per line, even with a divided ce.
  - frame_start is the same, additionally requiring v_cnt==0.
- Idle, entered when sync_en=0:
  - Takes effect on the next edge regardless of pixel_ce.
  - Counters are cleared to 0; vga_hc=vga_vc=0, vga_on=0, strobes=0.
  - Syncs go to the inactive level (~H_SYNC_POL, ~V_SYNC_POL).
- Deasserting sync_en mid-frame aborts the frame. On re-enable, timing restarts at (0,0) with frame_start.
- Reset values: counters 0; vga_hc=vga_vc=0; vga_on=0; line_start=frame_start=0; vga_hsync=~H_SYNC_POL; vga_vsync=~V_SYNC_POL.
- First qualifying tick after reset or enable: outputs show (0,0) with vga_on=1 and both strobes=1.
- Arithmetic: comparisons are unsigned at counter width. No counter ever reaches H_TOTAL or V_TOTAL.

Optional Feature:
VGA_SYNC_FRAME_CNT_EN
- Defined:
  - Adds output vga_frame [7:0].
  - Reset value 0; cleared in idle.
  - Increments, wrapping 255->0, on the same edge that registers frame_start=1, except the first frame after reset or enable, which reports 0.
  - Use: blink/animation logic.
- Undefined: port and logic are absent.

Test Plan:
- Defaults, pixel_ce=1, sync_en=1 after reset -> frame_start every 420000 cycles; line_start every 800 cycles; vga_on high 640 of 800 cycles on lines 0-479 and low on lines 480-524.
- Defaults -> vga_hsync low exactly while vga_hc is 656..751; vga_vsync low exactly while vga_vc is 490..491. Check inactive level at reset and in idle.
- H_SYNC_POL=1, V_SYNC_POL=1 -> same windows, active-high.
- pixel_ce toggling every other cycle -> counts advance every 2 cycles; line period 1600 cycles; line_start still exactly 1 cycle wide.
- Drop sync_en at vga_hc=300, vga_vc=100 for 5 cycles, then raise it -> idle outputs on the next edge; restart at (0,0) with frame_start=1 on the first ce tick.
- Small mode (H 4/1/2/1, V 3/1/1/1, H_SIZE=V_SIZE=4) -> wrap at hc=7 and vc=5 verified. With VGA_SYNC_FRAME_CNT_EN, vga_frame reads 0,1,2,... across frames and wraps 255->0.
